bulls_cows_engine: RTL and testbench



---
 rtl/bulls_cows_engine_if.sv | 33 +++
 rtl/bulls_cows_engine.sv | 201 ++++++++++++++++++++
 tb/tb_bulls_cows_engine.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bulls_cows_engine_if.sv
// Command/result port of the Bulls-and-Cows game core.
// The engine drives everything on the slave side except the command fields.
interface bulls_cows_engine_if #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned MAX_TRIES = 10
);
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd;
    logic [DIGITS*DW-1:0]   value_in;
    logic                   result_valid;
    logic [CW-1:0]          num_a;
    logic [CW-1:0]          num_b;
    logic [TW-1:0]          tries;
    logic                   err;
    logic                   win;
    logic                   lose;
    logic [2:0]             state_o;

    modport master (
        output cmd_valid, cmd, value_in,
        input  cmd_ready, result_valid, num_a, num_b, tries, err, win, lose, state_o
    );

    modport slave (
        input  cmd_valid, cmd, value_in,
        output cmd_ready, result_valid, num_a, num_b, tries, err, win, lose, state_o
    );
endinterface

// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows game core: latches a secret, scores guesses one digit per cycle,
// enforces code validity and a try limit, and reports win/lose.
module bulls_cows_engine #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned RADIX     = 10,
    parameter int unsigned MAX_TRIES = 10
) (
    input  logic               clk,
    input  logic               rst,
    bulls_cows_engine_if.slave bus
);
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);
    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned VW = DIGITS * DW;

    localparam logic [1:0] CMD_SET_SOL = 2'd0;
    localparam logic [1:0] CMD_GUESS   = 2'd1;
    localparam logic [1:0] CMD_RESTART = 2'd2;

    typedef enum logic [2:0] {
        S_SET   = 3'd0,
        S_GUESS = 3'd1,
        S_CMP   = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    // Digit 0 is the leftmost (most significant) field of the code.
    function automatic logic [DW-1:0] digit(input logic [VW-1:0] v, input int unsigned i);
        return v[(DIGITS-1-i)*DW +: DW];
    endfunction

    function automatic logic code_ok(input logic [VW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (32'(digit(v, i)) >= RADIX) ok = 1'b0;
            for (int unsigned j = i + 1; j < DIGITS; j++) begin
                if (digit(v, i) == digit(v, j)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    state_t          state, state_nxt;
    logic [VW-1:0]   sol, sol_nxt;
    logic [VW-1:0]   gss, gss_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [CW-1:0]   acc_a, acc_a_nxt, acc_b, acc_b_nxt;
    logic [CW-1:0]   num_a, num_a_nxt, num_b, num_b_nxt;
    logic [TW-1:0]   tries, tries_nxt;
    logic            result_valid, result_valid_nxt;
    logic            err, err_nxt;
    logic            win, win_nxt;
    logic            lose, lose_nxt;

    logic            fire;
    logic            code_valid;
    logic [DW-1:0]   cur_g;
    logic            hit;
    logic            cow;
    logic [CW-1:0]   fin_a, fin_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_SET;
            sol          <= '0;
            gss          <= '0;
            idx          <= '0;
            acc_a        <= '0;
            acc_b        <= '0;
            num_a        <= '0;
            num_b        <= '0;
            tries        <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            state        <= state_nxt;
            sol          <= sol_nxt;
            gss          <= gss_nxt;
            idx          <= idx_nxt;
            acc_a        <= acc_a_nxt;
            acc_b        <= acc_b_nxt;
            num_a        <= num_a_nxt;
            num_b        <= num_b_nxt;
            tries        <= tries_nxt;
            result_valid <= result_valid_nxt;
            err          <= err_nxt;
            win          <= win_nxt;
            lose         <= lose_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        sol_nxt          = sol;
        gss_nxt          = gss;
        idx_nxt          = idx;
        acc_a_nxt        = acc_a;
        acc_b_nxt        = acc_b;
        num_a_nxt        = num_a;
        num_b_nxt        = num_b;
        tries_nxt        = tries;
        result_valid_nxt = 1'b0;
        err_nxt          = 1'b0;
        win_nxt          = win;
        lose_nxt         = lose;

        fire       = bus.cmd_valid && (state != S_CMP);
        code_valid = code_ok(bus.value_in);

        // Score of the digit at idx; a cow is a match anywhere but its own slot.
        cur_g = digit(gss, 32'(idx));
        hit   = (cur_g == digit(sol, 32'(idx)));
        cow   = 1'b0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if ((IW'(j) != idx) && (digit(sol, j) == cur_g)) cow = 1'b1;
        end
        fin_a = acc_a + CW'(hit);
        fin_b = acc_b + CW'(!hit && cow);

        case (state)
            S_SET: begin
                if (fire) begin
                    if (bus.cmd == CMD_SET_SOL && code_valid) begin
                        sol_nxt   = bus.value_in;
                        tries_nxt = '0;
                        win_nxt   = 1'b0;
                        lose_nxt  = 1'b0;
                        state_nxt = S_GUESS;
                    end else if (bus.cmd != CMD_RESTART) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_GUESS: begin
                if (fire) begin
                    if (bus.cmd == CMD_GUESS && code_valid) begin
                        gss_nxt   = bus.value_in;
                        tries_nxt = tries + TW'(1);
                        acc_a_nxt = '0;
                        acc_b_nxt = '0;
                        idx_nxt   = '0;
                        state_nxt = S_CMP;
                    end else if (bus.cmd == CMD_RESTART) begin
                        tries_nxt = '0;
                        state_nxt = S_SET;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_CMP: begin
                acc_a_nxt = fin_a;
                acc_b_nxt = fin_b;
                idx_nxt   = idx + IW'(1);
                if (idx == IW'(DIGITS - 1)) begin
                    num_a_nxt        = fin_a;
                    num_b_nxt        = fin_b;
                    result_valid_nxt = 1'b1;
                    if (fin_a == CW'(DIGITS)) begin
                        win_nxt   = 1'b1;
                        state_nxt = S_WIN;
                    end else if (tries == TW'(MAX_TRIES)) begin
                        lose_nxt  = 1'b1;
                        state_nxt = S_LOSE;
                    end else begin
                        state_nxt = S_GUESS;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (fire) begin
                    if (bus.cmd == CMD_RESTART) begin
                        win_nxt   = 1'b0;
                        lose_nxt  = 1'b0;
                        tries_nxt = '0;
                        state_nxt = S_SET;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_SET;
        endcase
    end

    assign bus.cmd_ready    = (state != S_CMP);
    assign bus.result_valid = result_valid;
    assign bus.num_a        = num_a;
    assign bus.num_b        = num_b;
    assign bus.tries        = tries;
    assign bus.err          = err;
    assign bus.win          = win;
    assign bus.lose         = lose;
    assign bus.state_o      = state;
endmodule

// File: tb/tb_bulls_cows_engine.sv
// Scoreboard bench for bulls_cows_engine: a 4-digit core with a 3-try limit and
// a 6-digit core, sharing one stimulus bus selected by sel.
module tb_bulls_cows_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [23:0] val;
    logic        sel;

    always #5 clk = ~clk;

    bulls_cows_engine_if #(.DIGITS(4), .DW(4), .MAX_TRIES(3))  bus4 ();
    bulls_cows_engine_if #(.DIGITS(6), .DW(4), .MAX_TRIES(10)) bus6 ();

    bulls_cows_engine #(.DIGITS(4), .DW(4), .RADIX(10), .MAX_TRIES(3)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    bulls_cows_engine #(.DIGITS(6), .DW(4), .RADIX(10), .MAX_TRIES(10)) u6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.slave)
    );

    assign bus4.cmd_valid = cmd_valid && !sel;
    assign bus4.cmd       = cmd;
    assign bus4.value_in  = val[15:0];
    assign bus6.cmd_valid = cmd_valid && sel;
    assign bus6.cmd       = cmd;
    assign bus6.value_in  = val;

    logic       ready, rv, err, win, lose;
    logic [2:0] st;
    logic [3:0] na, nb, tr;

    always_comb begin
        ready = sel ? bus6.cmd_ready    : bus4.cmd_ready;
        rv    = sel ? bus6.result_valid : bus4.result_valid;
        err   = sel ? bus6.err          : bus4.err;
        win   = sel ? bus6.win          : bus4.win;
        lose  = sel ? bus6.lose         : bus4.lose;
        st    = sel ? bus6.state_o      : bus4.state_o;
        na    = sel ? 4'(bus6.num_a)    : 4'(bus4.num_a);
        nb    = sel ? 4'(bus6.num_b)    : 4'(bus4.num_b);
        tr    = sel ? 4'(bus6.tries)    : 4'(bus4.tries);
    end

    typedef struct {
        int a;
        int b;
        int t;
        int w;
        int l;
        int s;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model of the game as seen from the command port.
    int          m_st;
    int          m_tries;
    logic [23:0] m_sol;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dig(input logic [23:0] v, input int ndig, input int i);
        logic [23:0] s;
        s = v >> ((ndig - 1 - i) * 4);
        return int'(s[3:0]);
    endfunction

    function automatic bit code_ok(input logic [23:0] v, input int ndig);
        for (int i = 0; i < ndig; i++) begin
            if (dig(v, ndig, i) > 9) return 1'b0;
            for (int j = 0; j < i; j++)
                if (dig(v, ndig, i) == dig(v, ndig, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic score(input logic [23:0] s, input logic [23:0] g, input int ndig,
                         output int a, output int b);
        a = 0;
        b = 0;
        for (int i = 0; i < ndig; i++) begin
            if (dig(g, ndig, i) == dig(s, ndig, i)) a++;
            else for (int j = 0; j < ndig; j++)
                if (dig(g, ndig, i) == dig(s, ndig, j)) b++;
        end
    endtask

    // Issues one command at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [1:0] c, input logic [23:0] v);
        int   ndig, maxt, a, b;
        bit   ok, e_err, is_guess;
        exp_t e;
        ndig = sel ? 6 : 4;
        maxt = sel ? 10 : 3;
        ok = code_ok(v, ndig);
        e_err = 1'b0;
        is_guess = 1'b0;
        case (m_st)
            0: begin
                if (c == 2'd0 && ok) begin
                    m_sol = v; m_tries = 0; m_st = 1;
                end else if (c != 2'd2) e_err = 1'b1;
            end
            1: begin
                if (c == 2'd1 && ok) begin
                    is_guess = 1'b1;
                    m_tries++;
                    score(m_sol, v, ndig, a, b);
                    if (a == ndig) m_st = 3;
                    else if (m_tries == maxt) m_st = 4;
                    else m_st = 1;
                    e.a = a; e.b = b; e.t = m_tries;
                    e.w = (m_st == 3) ? 1 : 0;
                    e.l = (m_st == 4) ? 1 : 0;
                    e.s = m_st;
                    sb.push_back(e);
                end else if (c == 2'd2) begin
                    m_st = 0; m_tries = 0;
                end else e_err = 1'b1;
            end
            default: begin
                if (c == 2'd2) begin
                    m_st = 0; m_tries = 0;
                end else e_err = 1'b1;
            end
        endcase
        for (int k = 0; k < 50 && !ready; k++) @(negedge clk);
        chk("ready", int'(ready), 1);
        cmd = c;
        val = v;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("err", int'(err), int'(e_err));
        if (!is_guess) begin
            chk("state", int'(st), m_st);
            chk("tries", int'(tr), m_tries);
            chk("win", int'(win), (m_st == 3) ? 1 : 0);
            chk("lose", int'(lose), (m_st == 4) ? 1 : 0);
        end
    endtask

    // Waits for the score of the guess just accepted; optionally keeps a command
    // asserted throughout scoring to show it is ignored.
    task automatic await_result(input bit hold);
        int ndig, k, lowc;
        ndig = sel ? 6 : 4;
        lowc = 0;
        if (hold) begin
            cmd = 2'd0;
            val = 24'h001234;
            cmd_valid = 1'b1;
        end
        for (k = 1; k <= 20; k++) begin
            if (rv) break;
            if (!ready) lowc++;
            @(negedge clk);
        end
        chk("latency", k, ndig + 1);
        chk("ready_low", lowc, ndig);
        if (hold) begin
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("held_err", int'(err), 0);
            chk("held_state", int'(st), m_st);
        end
    endtask

    task automatic guess(input logic [23:0] v, input bit hold);
        send(2'd1, v);
        await_result(hold);
    endtask

    task automatic check_reset_values();
        chk("rst_state", int'(st), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_rv", int'(rv), 0);
        chk("rst_num_a", int'(na), 0);
        chk("rst_num_b", int'(nb), 0);
        chk("rst_tries", int'(tr), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_lose", int'(lose), 0);
    endtask

    // Result monitor: pops the scoreboard on every score and checks a/b hold otherwise.
    logic [3:0] prev_na, prev_nb;
    logic       prev_sel, prev_rst;
    always @(negedge clk) begin
        exp_t e;
        if (rv) begin
            if (sb.size() == 0) chk("unexpected_rv", 1, 0);
            else begin
                e = sb.pop_front();
                chk("num_a", int'(na), e.a);
                chk("num_b", int'(nb), e.b);
                chk("res_tries", int'(tr), e.t);
                chk("res_win", int'(win), e.w);
                chk("res_lose", int'(lose), e.l);
                chk("res_state", int'(st), e.s);
            end
        end else if (!rst && !prev_rst && sel == prev_sel &&
                     (na != prev_na || nb != prev_nb)) begin
            chk("ab_hold", int'({na, nb}), int'({prev_na, prev_nb}));
        end
        prev_na  <= na;
        prev_nb  <= nb;
        prev_sel <= sel;
        prev_rst <= rst;
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd = 2'd0;
        val = '0;
        sel = 1'b0;
        m_st = 0;
        m_tries = 0;
        m_sol = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Rejections in S_SET, then a game won on the final allowed try.
        send(2'd0, 24'h001123);
        send(2'd1, 24'h001234);
        send(2'd2, 24'h000000);
        send(2'd0, 24'h001234);
        send(2'd1, 24'h0012A4);
        send(2'd0, 24'h005678);
        send(2'd3, 24'h005678);
        guess(24'h001243, 1'b1);
        guess(24'h005678, 1'b0);
        guess(24'h001234, 1'b0);
        send(2'd1, 24'h004321);
        send(2'd2, 24'h000000);

        // Three misses exhaust the try limit.
        send(2'd0, 24'h009876);
        guess(24'h001234, 1'b0);
        guess(24'h006789, 1'b0);
        guess(24'h009867, 1'b0);
        send(2'd1, 24'h001234);
        send(2'd2, 24'h000000);

        // Reset two cycles into scoring aborts without a result.
        send(2'd0, 24'h001234);
        send(2'd1, 24'h004321);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        m_st = 0;
        m_tries = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        repeat (6) @(negedge clk);
        chk("no_late_rv", int'(rv), 0);

        // Six-digit core.
        sel = 1'b1;
        m_st = 0;
        m_tries = 0;
        @(negedge clk);
        send(2'd0, 24'h012345);
        guess(24'h543210, 1'b0);
        guess(24'h012354, 1'b0);
        guess(24'h012345, 1'b0);
        send(2'd2, 24'h000000);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
